// File: rtl/lc3_control_unit.sv
// lc3_control_unit: LC3 pipeline controller producing stage enables, operand bypass selects,
// the data-memory access sequence and the branch-taken flag.
module lc3_control_unit #(
  parameter int STARTUP_STAGES = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_data,
  input  logic        complete_instr,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  input  logic [2:0]  NZP,
  input  logic [15:0] Instr_dout,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [2:0] START_DONE = 3'(STARTUP_STAGES);
  typedef enum logic [1:0] {READ, IND, WRITE, IDLE} mem_state_e;
  mem_state_e mem_state_q, mem_state_d;
  logic [2:0] start_q, start_d;
  logic [FW-1:0] flush_q, flush_d;
  logic en_pc_q, en_pc_d, en_fetch_q, en_fetch_d, en_dec_q, en_dec_d;
  logic en_exe_q, en_exe_d, en_wb_q, en_wb_d;
  logic [3:0] dec_op, exe_op;
  logic exe_alu, exe_load, dec_sr1, dec_sr2, quiet, sr1_hit, sr2_hit, busy_next;
  logic unused_bits;
  // Early BR/JMP peeking is not used: control hazards are handled only by the flush.
  assign unused_bits = ^{Instr_dout, IR[11:9], IR[4:3], IR_Exec[8:0]};
  assign dec_op = IR[15:12];
  assign exe_op = IR_Exec[15:12];
  assign enable_updatePC = en_pc_q;
  assign enable_fetch = en_fetch_q;
  assign enable_decode = en_dec_q;
  assign enable_execute = en_exe_q;
  assign enable_writeback = en_wb_q;
  assign mem_state = mem_state_q;
  always_comb begin
    exe_alu = exe_op inside {4'b0001, 4'b0101, 4'b1001, 4'b1110};
    exe_load = exe_op inside {4'b0010, 4'b0110, 4'b1010};
    dec_sr1 = dec_op inside {4'b0001, 4'b0101, 4'b1001, 4'b0110, 4'b0111, 4'b1100};
    dec_sr2 = (dec_op inside {4'b0001, 4'b0101}) & ~IR[5];
    quiet = (flush_q != '0) | (start_q != START_DONE);
    sr1_hit = ~quiet & dec_sr1 & (IR[8:6] == IR_Exec[11:9]);
    sr2_hit = ~quiet & dec_sr2 & (IR[2:0] == IR_Exec[11:9]);
    bypass_alu_1 = sr1_hit & exe_alu;
    bypass_alu_2 = sr2_hit & exe_alu;
    bypass_mem_1 = sr1_hit & exe_load;
    bypass_mem_2 = sr2_hit & exe_load;
    br_taken = en_exe_q & (((exe_op == 4'b0000) & |(NZP & psr)) | (exe_op == 4'b1100));
    mem_state_d = mem_state_q;
    case (mem_state_q)
      IDLE: if (en_exe_q) mem_state_d = (exe_op inside {4'b0010, 4'b0110}) ? READ :
                                        (exe_op inside {4'b0011, 4'b0111}) ? WRITE :
                                        (exe_op inside {4'b1010, 4'b1011}) ? IND : IDLE;
      IND: if (complete_data) mem_state_d = (exe_op == 4'b1010) ? READ : WRITE;
      default: if (complete_data) mem_state_d = IDLE;
    endcase
    busy_next = mem_state_d != IDLE;
    // The flush count holds while a memory access owns the pipeline.
    flush_d = br_taken ? FW'(FLUSH_CYCLES) :
              ((mem_state_q != IDLE) | (flush_q == '0)) ? flush_q : flush_q - FW'(1);
    start_d = (start_q == START_DONE) ? start_q : start_q + 3'd1;
    en_pc_d = (start_d >= 3'd1) & complete_instr & ~busy_next;
    en_fetch_d = en_pc_d;
    en_dec_d = (start_d >= 3'd2) & (flush_d == '0) & ~busy_next;
    en_exe_d = (start_d >= 3'd3) & (flush_d == '0) & ~busy_next;
    en_wb_d = (mem_state_q != IDLE) ? ((mem_state_q == READ) & complete_data) :
              (start_d >= 3'd4) & (flush_d == '0) & ~busy_next;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_state_q <= IDLE;
      start_q <= '0;
      flush_q <= '0;
      en_pc_q <= 1'b0;
      en_fetch_q <= 1'b0;
      en_dec_q <= 1'b0;
      en_exe_q <= 1'b0;
      en_wb_q <= 1'b0;
    end else begin
      mem_state_q <= mem_state_d;
      start_q <= start_d;
      flush_q <= flush_d;
      en_pc_q <= en_pc_d;
      en_fetch_q <= en_fetch_d;
      en_dec_q <= en_dec_d;
      en_exe_q <= en_exe_d;
      en_wb_q <= en_wb_d;
    end
  end
endmodule

// File: tb/tb_lc3_control_unit.sv
// tb_lc3_control_unit: directed scoreboard bench for lc3_control_unit.
module tb_lc3_control_unit;
  logic clock = 1'b0, reset = 1'b0, complete_data = 1'b0, complete_instr = 1'b1;
  logic [15:0] IR = '0, IR_Exec = '0, Instr_dout = '0;
  logic [2:0] psr = '0, NZP = '0;
  logic enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0] mem_state;
  logic [11:0] obs;
  typedef struct {string tag; logic [11:0] exp;} item_t;
  item_t sb[$];
  int vectors = 0, miscompares = 0;
  always #5 clock = ~clock;
  lc3_control_unit dut (
    .clock(clock), .reset(reset), .complete_data(complete_data), .complete_instr(complete_instr),
    .IR(IR), .IR_Exec(IR_Exec), .psr(psr), .NZP(NZP), .Instr_dout(Instr_dout),
    .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch), .enable_decode(enable_decode),
    .enable_execute(enable_execute), .enable_writeback(enable_writeback), .br_taken(br_taken),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2), .bypass_mem_1(bypass_mem_1),
    .bypass_mem_2(bypass_mem_2), .mem_state(mem_state)
  );
  assign obs = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
                br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state};
  // {pc,fetch,decode,execute,writeback}, br_taken, {alu1,alu2,mem1,mem2}, mem_state
  function automatic logic [11:0] ev(input logic [4:0] en, input logic br, input logic [3:0] byp,
                                     input logic [1:0] ms);
    return {en, br, byp, ms};
  endfunction
  task automatic chk(input string tag, input logic [11:0] exp);
    item_t it;
    sb.push_back('{tag, exp});
    @(negedge clock);
    it = sb.pop_front();
    vectors++;
    assert (obs === it.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", it.tag, obs, it.exp);
    end
    @(posedge clock);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1);
  end
  initial begin
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) chk("reset", ev(5'b00000, 0, 4'b0000, 2'd3));
    reset = 1'b1;
    chk("su0", ev(5'b00000, 0, 4'b0000, 2'd3));
    chk("su1", ev(5'b11000, 0, 4'b0000, 2'd3));
    chk("su2", ev(5'b11100, 0, 4'b0000, 2'd3));
    chk("su3", ev(5'b11110, 0, 4'b0000, 2'd3));
    chk("su4", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR = 16'h1042; IR_Exec = 16'h1220;
    chk("byp_alu1", ev(5'b11111, 0, 4'b1000, 2'd3));
    IR = 16'h1001;
    chk("byp_alu2", ev(5'b11111, 0, 4'b0100, 2'd3));
    IR = 16'hE040;
    chk("byp_lea", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR = 16'h1042; IR_Exec = 16'hA200;
    chk("ldi_go", ev(5'b11111, 0, 4'b0010, 2'd3));
    IR = 16'h0000;
    chk("ind_w0", ev(5'b00000, 0, 4'b0000, 2'd1));
    chk("ind_w1", ev(5'b00000, 0, 4'b0000, 2'd1));
    complete_data = 1'b1;
    chk("ind_done", ev(5'b00000, 0, 4'b0000, 2'd1));
    complete_data = 1'b0;
    for (int i = 0; i < 3; i++) chk("rd_wait", ev(5'b00000, 0, 4'b0000, 2'd0));
    complete_data = 1'b1; IR_Exec = 16'h0000;
    chk("rd_done", ev(5'b00000, 0, 4'b0000, 2'd0));
    complete_data = 1'b0;
    chk("ldi_wb", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR = 16'h1001; IR_Exec = 16'h2200;
    chk("ld_go", ev(5'b11111, 0, 4'b0001, 2'd3));
    IR = 16'h0000; IR_Exec = 16'h0000; complete_data = 1'b1;
    chk("ld_rd", ev(5'b00000, 0, 4'b0000, 2'd0));
    complete_data = 1'b0;
    chk("ld_wb", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR_Exec = 16'h0E05; psr = 3'b010; NZP = 3'b111;
    chk("br_taken", ev(5'b11111, 1, 4'b0000, 2'd3));
    IR = 16'h1042; IR_Exec = 16'h1220; NZP = 3'b000;
    chk("br_fl0", ev(5'b11000, 0, 4'b0000, 2'd3));
    chk("br_fl1", ev(5'b11000, 0, 4'b0000, 2'd3));
    chk("br_end", ev(5'b11111, 0, 4'b1000, 2'd3));
    IR = 16'h0000; IR_Exec = 16'h0E05; NZP = 3'b100;
    chk("br_not", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR_Exec = 16'h0000;
    chk("br_nofl", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR_Exec = 16'hC1C0; NZP = 3'b000;
    chk("jmp", ev(5'b11111, 1, 4'b0000, 2'd3));
    IR_Exec = 16'h0000;
    chk("jmp_fl0", ev(5'b11000, 0, 4'b0000, 2'd3));
    chk("jmp_fl1", ev(5'b11000, 0, 4'b0000, 2'd3));
    chk("jmp_end", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR_Exec = 16'h3205;
    chk("st_go", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR_Exec = 16'h0000;
    for (int i = 0; i < 5; i++) chk("st_wait", ev(5'b00000, 0, 4'b0000, 2'd2));
    complete_data = 1'b1;
    chk("st_done", ev(5'b00000, 0, 4'b0000, 2'd2));
    complete_data = 1'b0;
    chk("st_idle", ev(5'b11110, 0, 4'b0000, 2'd3));
    chk("st_after", ev(5'b11111, 0, 4'b0000, 2'd3));
    complete_instr = 1'b0;
    chk("ci_lo", ev(5'b11111, 0, 4'b0000, 2'd3));
    complete_instr = 1'b1;
    chk("ci_stall", ev(5'b00111, 0, 4'b0000, 2'd3));
    chk("ci_back", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR_Exec = 16'hA200;
    chk("ind_go2", ev(5'b11111, 0, 4'b0000, 2'd3));
    IR_Exec = 16'h0000;
    chk("ind2", ev(5'b00000, 0, 4'b0000, 2'd1));
    reset = 1'b0;
    chk("rst_mid_pre", ev(5'b00000, 0, 4'b0000, 2'd1));
    reset = 1'b1;
    chk("rst_mid", ev(5'b00000, 0, 4'b0000, 2'd3));
    chk("rst_su1", ev(5'b11000, 0, 4'b0000, 2'd3));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
